// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB first, zero fill at the MSB.
// Define PISO_DONE_EN to add a bit counter and a registered last-bit `done` pulse.
module piso_shift_reg #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             shift,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] so,
  output logic             out
`ifdef PISO_DONE_EN
  ,
  output logic             done
`endif
);

  logic [WIDTH-1:0] r_so;

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_so <= '0;
    end else if (shift) begin
      r_so <= {1'b0, r_so[WIDTH-1:1]};
    end else begin
      r_so <= x;
    end
  end

  assign so  = r_so;
  assign out = r_so[0];

`ifdef PISO_DONE_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] r_cnt;
  logic          r_done;

  // done fires on the shift edge that consumes the last loaded bit (cnt 1 -> 0)
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (!shift) begin
      r_cnt  <= CW'(WIDTH);
      r_done <= 1'b0;
    end else if (r_cnt != '0) begin
      r_cnt  <= r_cnt - CW'(1);
      r_done <= (r_cnt == CW'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign done = r_done;
`endif

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg (WIDTH=6); covers the done pulse when PISO_DONE_EN is defined.
module tb_piso_shift_reg;

  localparam int WIDTH = 6;

  logic             clk;
  logic             clr;
  logic             shift;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] so;
  logic             out;
`ifdef PISO_DONE_EN
  logic             done;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  piso_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .clr   (clr),
    .shift (shift),
    .x     (x),
    .so    (so),
    .out   (out)
`ifdef PISO_DONE_EN
    ,
    .done  (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected register contents after each shift edge following a load of 101101.
  localparam logic [5:0] SHIFT_EXP [6] = '{6'b010110, 6'b001011, 6'b000101,
                                            6'b000010, 6'b000001, 6'b000000};
  // Serial bit consumed on each of those edges, LSB first.
  localparam logic       SER_EXP   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [5:0] LOAD_SEQ  [3] = '{6'b000001, 6'b111110, 6'b010101};

  initial begin
    clr   = 1'b1;
    shift = 1'b0;
    x     = 6'b111111;
    @(negedge clk);

    // Preset nonzero contents, then reset while shift/x wiggle.
    step();
    check("preset_so", 32'(so), 32'(6'b111111));
    clr = 1'b0; shift = 1'b1; x = 6'b101010;
    step();
    check("rst1_so",  32'(so),  32'(6'b000000));
    check("rst1_out", 32'(out), 32'(1'b0));
    shift = 1'b0; x = 6'b110011;
    step();
    check("rst2_so",  32'(so),  32'(6'b000000));
    check("rst2_out", 32'(out), 32'(1'b0));

    // Shifting a cleared register stays zero; x is ignored.
    clr = 1'b1; shift = 1'b1; x = 6'b100100;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("clrshift%0d_so", i),  32'(so),  32'(6'b000000));
      check($sformatf("clrshift%0d_out", i), 32'(out), 32'(1'b0));
    end

    // Load then shift the full word out.
    shift = 1'b0; x = 6'b101101;
    step();
    check("load_so",  32'(so),  32'(6'b101101));
    check("load_out", 32'(out), 32'(1'b1));
    shift = 1'b1; x = 6'b010010;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("ser%0d_bit", i), 32'(out), 32'(SER_EXP[i]));
      step();
      check($sformatf("sh%0d_so", i),  32'(so),  32'(SHIFT_EXP[i]));
      check($sformatf("sh%0d_out", i), 32'(out), 32'(SHIFT_EXP[i][0]));
    end
    step();
    check("sh7_so",  32'(so),  32'(6'b000000));
    check("sh7_out", 32'(out), 32'(1'b0));

    // Continuous load follows x one edge later.
    shift = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x = LOAD_SEQ[i];
      step();
      check($sformatf("cload%0d_so", i),  32'(so),  32'(LOAD_SEQ[i]));
      check($sformatf("cload%0d_out", i), 32'(out), 32'(LOAD_SEQ[i][0]));
    end

    // Reset mid-transfer aborts the word.
    x = 6'b111111;
    step();
    check("mid_load", 32'(so), 32'(6'b111111));
    shift = 1'b1;
    step();
    step();
    check("mid_sh2", 32'(so), 32'(6'b001111));
    clr = 1'b0;
    step();
    check("mid_rst_so",  32'(so),  32'(6'b000000));
    check("mid_rst_out", 32'(out), 32'(1'b0));
    clr = 1'b1;
    step();
    check("mid_rel1", 32'(so), 32'(6'b000000));
    step();
    check("mid_rel2", 32'(so), 32'(6'b000000));

`ifdef PISO_DONE_EN
    check("done_after_rst", 32'(done), 32'(1'b0));
    for (int pass = 0; pass < 2; pass++) begin
      shift = 1'b0; x = 6'b110011;
      step();
      check($sformatf("dload%0d_so", pass),   32'(so),   32'(6'b110011));
      check($sformatf("dload%0d_done", pass), 32'(done), 32'(1'b0));
      shift = 1'b1;
      for (int i = 1; i <= 6; i++) begin
        step();
        check($sformatf("d%0d_sh%0d", pass, i), 32'(done), 32'((i == 6) ? 1'b1 : 1'b0));
      end
      step();
      check($sformatf("d%0d_after", pass), 32'(done), 32'(1'b0));
    end
    clr = 1'b0;
    step();
    check("done_rst", 32'(done), 32'(1'b0));
    clr = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
